strobe_period_meter: RTL and testbench
======================================

STROBE_PERIOD_METER -- requirements
Module: strobe_period_meter

Interface
REQ-001 Parameter CNT_W, default 8: width of the period counter and period_out.
REQ-002 Parameter LOCK_CNT, default 3: number of consecutive equal periods required to assert locked; legal range 2..15.
REQ-003 clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 strobe_in  input  1  single-cycle clock-enable flag from a divider, synchronous to clk_in.
REQ-006 period_out  output  CNT_W  last measured strobe period, in clk_in cycles.
REQ-007 period_valid  output  1  one-cycle pulse: period_out updated this cycle.
REQ-008 locked  output  1  high while the strobe period is stable.
REQ-009 timeout  output  1  one-cycle pulse: no strobe within 2^CNT_W-1 cycles.

Function
REQ-010 The period SHALL equal the clk_in cycle count between consecutive sampled strobes; a divide-by-6 flag measures 6, and strobe_in held high measures 1.
REQ-011 Counter cnt SHALL clear to 0 on every sampled strobe and otherwise increment; measured period = cnt+1.
REQ-012 period_out and period_valid SHALL register one cycle after the sampled strobe (latency 1).
REQ-013 FSM states SHALL be IDLE (no reference strobe yet), TRACK (measuring, not locked) and LOCKED.
REQ-014 IDLE -> TRACK on the first strobe; this strobe produces no period_valid.
REQ-015 In TRACK, every strobe produces period_valid; match_cnt increments when the period equals the previous period, and otherwise reloads to 1.
REQ-016 TRACK -> LOCKED when match_cnt reaches LOCK_CNT; locked rises in the same cycle as that period_valid.
REQ-017 In LOCKED, a period differing from the locked value SHALL go to TRACK, drop locked in the same cycle as period_valid, and set match_cnt to 1.
REQ-018 If cnt reaches 2^CNT_W-1 with no strobe, the block SHALL pulse timeout for one cycle, go to IDLE, drop locked, clear cnt and match_cnt, and hold period_out.
REQ-019 If a strobe arrives in the same cycle cnt reaches 2^CNT_W-1, the strobe SHALL win: the period 2^CNT_W is reported as 0, with no timeout.
REQ-020 period_valid and timeout SHALL never be high in the same cycle.

Reset
REQ-021 Reset SHALL force state IDLE, cnt 0, match_cnt 0, period_out 0, period_valid 0, locked 0 and timeout 0, asynchronously and at any point mid-measurement.
REQ-022 The first strobe after reset deassertion SHALL be treated as the IDLE reference strobe.

Configuration
REQ-023 Macro STROBE_METER_EDGE_EN defined: only the rising edge of strobe_in is a strobe (strobe_in & ~strobe_q), so 50%-duty divided clocks can be measured, and latency is unchanged.
REQ-024 Macro STROBE_METER_EDGE_EN undefined: every cycle with strobe_in high is a strobe, no edge register exists, and strobe_q is absent.

Structure
REQ-025 Package strobe_meter_pkg SHALL hold the FSM state enum typedef (IDLE, TRACK, LOCKED) and the default CNT_W and LOCK_CNT constants.
REQ-026 Edge detection SHALL be sub-module strobe_edge_det, instantiated only under STROBE_METER_EDGE_EN.
REQ-027 The FSM, counter and lock logic SHALL stay in strobe_period_meter.

Verification
REQ-028 Divide-by-6 one-cycle flag for 5 strobes -> period_valid pulses with period_out 6, and locked rises with the 4th strobe's (3rd) valid.
REQ-029 Locked at period 6, then one gap of 5 cycles -> period_out 5 and locked falls in that cycle; three further periods of 5 -> locked rises again.
REQ-030 CNT_W=4, no strobe for 15 cycles after the reference strobe -> timeout pulses once, locked 0, and the next strobe produces no period_valid.
REQ-031 strobe_in held constantly high -> period_out 1 every cycle, and locked after LOCK_CNT cycles (macro undefined); with the macro defined -> no further strobes, so timeout.
REQ-032 With the macro defined, a 50%-duty clock of period 10 -> period_out 10 and locked; with the macro undefined -> periods alternate 1/6, and locked occurs only on the run of 1s.
REQ-033 Reset asserted mid-TRACK and mid-LOCKED -> all outputs 0 immediately; first strobe after release yields no period_valid.

Source files
------------

// File: rtl/strobe_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : strobe_meter_pkg
//  Purpose  : Shared FSM state type and default sizing for strobe_period_meter
//  Revision : 1.0
// ============================================================================
package strobe_meter_pkg;

    localparam int DEF_CNT_W    = 8;
    localparam int DEF_LOCK_CNT = 3;
    localparam int MATCH_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/strobe_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : strobe_edge_det
//  Purpose  : Converts strobe_in into a one-cycle pulse on its rising edge
//  Revision : 1.0
// ============================================================================
module strobe_edge_det (
    input  logic clk_in,
    input  logic reset,
    input  logic strobe_in,
    output logic strobe_pulse
);

    logic strobe_d;
    logic strobe_q;

    always_comb begin
        strobe_d = strobe_in;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign strobe_pulse = strobe_in & ~strobe_q;

endmodule
`default_nettype wire

// File: rtl/strobe_period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : strobe_period_meter
//  Purpose  : Measures strobe period in clk_in cycles, flags lock and timeout.
//             STROBE_METER_EDGE_EN: only rising edges of strobe_in count.
//  Revision : 1.0
// ============================================================================
module strobe_period_meter
    import strobe_meter_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             strobe_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_CNT);

    logic strobe_hit;

`ifdef STROBE_METER_EDGE_EN
    strobe_edge_det u_edge_det (
        .clk_in       (clk_in),
        .reset        (reset),
        .strobe_in    (strobe_in),
        .strobe_pulse (strobe_hit)
    );
`else
    assign strobe_hit = strobe_in;
`endif

    state_t             state_d,  state_q;
    logic [CNT_W-1:0]   cnt_d,    cnt_q;
    logic [MATCH_W-1:0] match_d,  match_q;
    logic [CNT_W-1:0]   period_d, period_q;
    logic               valid_d,  valid_q;
    logic               locked_d, locked_q;
    logic               timeout_d, timeout_q;
    logic [CNT_W-1:0]   meas;

    // A period of 2^CNT_W wraps to 0 here by construction.
    assign meas = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = meas;
        match_d   = match_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = 1'b0;

        if (strobe_hit) begin
            cnt_d = '0;
            if (state_q == IDLE) begin
                state_d = TRACK;
                match_d = '0;
            end else begin
                valid_d  = 1'b1;
                period_d = meas;
                if (meas != period_q) begin
                    match_d = MATCH_W'(1);
                end else if (match_q != LOCK_TGT) begin
                    match_d = match_q + 1'b1;
                end
                if (match_d == LOCK_TGT) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                end else begin
                    state_d  = TRACK;
                    locked_d = 1'b0;
                end
            end
        end else if ((cnt_q == CNT_MAX) && (state_q != IDLE)) begin
            // No strobe in the longest measurable window: drop the reference.
            timeout_d = 1'b1;
            state_d   = IDLE;
            locked_d  = 1'b0;
            cnt_d     = '0;
            match_d   = '0;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            match_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_strobe_period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_strobe_period_meter
//  Purpose  : Directed self-checking bench for strobe_period_meter
//  Revision : 1.0
// ============================================================================
module tb_strobe_period_meter;

    logic       clk;
    logic       rst;
    logic       strobe;
    logic [7:0] period;
    logic       valid;
    logic       lck;
    logic       tmo;
    logic [3:0] period4;
    logic       valid4;
    logic       lck4;
    logic       tmo4;

    int errors = 0;
    int checks = 0;

    strobe_period_meter #(.CNT_W(8), .LOCK_CNT(3)) dut (
        .clk_in       (clk),
        .reset        (rst),
        .strobe_in    (strobe),
        .period_out   (period),
        .period_valid (valid),
        .locked       (lck),
        .timeout      (tmo)
    );

    strobe_period_meter #(.CNT_W(4), .LOCK_CNT(3)) dut4 (
        .clk_in       (clk),
        .reset        (rst),
        .strobe_in    (strobe),
        .period_out   (period4),
        .period_valid (valid4),
        .locked       (lck4),
        .timeout      (tmo4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input logic s);
        strobe = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        strobe = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        strobe = 1'b0;
        #1;
        checks++; if (period !== 8'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", period); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (lck !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", lck); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", tmo); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_div6();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick(1'b1);
            checks++; if (valid !== (k > 0)) begin errors++; $display("FAIL div6_valid[%0d]: got %b want %b", k, valid, (k > 0)); end
            if (k > 0) begin
                checks++; if (period !== 8'd6) begin errors++; $display("FAIL div6_period[%0d]: got %0d want 6", k, period); end
                checks++; if (lck !== (k >= 3)) begin errors++; $display("FAIL div6_locked[%0d]: got %b want %b", k, lck, (k >= 3)); end
            end
            if (k < 4) begin
                tick(1'b0);
                checks++; if (valid !== 1'b0) begin errors++; $display("FAIL div6_gap_valid[%0d]: got %b want 0", k, valid); end
                repeat (4) tick(1'b0);
            end
        end
    endtask

    task automatic test_relock();
        repeat (4) tick(1'b0);
        tick(1'b1);
        checks++; if (period !== 8'd5) begin errors++; $display("FAIL relock_period: got %0d want 5", period); end
        checks++; if (lck !== 1'b0) begin errors++; $display("FAIL relock_drop: got %b want 0", lck); end
        for (int j = 0; j < 3; j++) begin
            repeat (4) tick(1'b0);
            tick(1'b1);
            checks++; if (period !== 8'd5) begin errors++; $display("FAIL relock_period5[%0d]: got %0d want 5", j, period); end
            checks++; if (lck !== (j >= 1)) begin errors++; $display("FAIL relock_locked[%0d]: got %b want %b", j, lck, (j >= 1)); end
        end
    endtask

    task automatic test_held_high();
        bit seen;
        do_reset();
        tick(1'b1);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL held_ref_valid: got %b want 0", valid); end
`ifdef STROBE_METER_EDGE_EN
        tick(1'b1);
        checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL held_edge_valid: got %b want 0", valid4); end
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick(1'b1);
            if (tmo4) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL held_edge_timeout: got %b want 1", seen); end
`else
        seen = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick(1'b1);
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL held_valid[%0d]: got %b want 1", k, valid); end
            checks++; if (period !== 8'd1) begin errors++; $display("FAIL held_period[%0d]: got %0d want 1", k, period); end
            checks++; if (lck !== (k >= 3)) begin errors++; $display("FAIL held_locked[%0d]: got %b want %b", k, lck, (k >= 3)); end
            if (tmo4) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL held_no_timeout: got %b want 0", seen); end
`endif
        tick(1'b0);
    endtask

    task automatic test_duty50();
        do_reset();
`ifdef STROBE_METER_EDGE_EN
        for (int c = 0; c < 40; c++) begin
            tick((c % 10) < 5);
            if (c == 10 || c == 30) begin
                checks++; if (valid !== 1'b1) begin errors++; $display("FAIL duty_valid[%0d]: got %b want 1", c, valid); end
                checks++; if (period !== 8'd10) begin errors++; $display("FAIL duty_period[%0d]: got %0d want 10", c, period); end
                checks++; if (lck !== (c == 30)) begin errors++; $display("FAIL duty_locked[%0d]: got %b want %b", c, lck, (c == 30)); end
            end
        end
`else
        for (int c = 0; c < 20; c++) begin
            tick((c % 10) < 5);
            if (c == 4 || c == 13) begin
                checks++; if (period !== 8'd1) begin errors++; $display("FAIL duty_period1[%0d]: got %0d want 1", c, period); end
                checks++; if (lck !== 1'b1) begin errors++; $display("FAIL duty_locked[%0d]: got %b want 1", c, lck); end
            end
            if (c == 10) begin
                checks++; if (period !== 8'd6) begin errors++; $display("FAIL duty_period6: got %0d want 6", period); end
                checks++; if (lck !== 1'b0) begin errors++; $display("FAIL duty_unlock: got %b want 0", lck); end
            end
        end
`endif
        tick(1'b0);
    endtask

    task automatic test_timeout();
        do_reset();
        tick(1'b1);
        repeat (3) tick(1'b0);
        tick(1'b1);
        checks++; if (period4 !== 4'd4) begin errors++; $display("FAIL tmo_pre_period: got %0d want 4", period4); end
        repeat (15) tick(1'b0);
        checks++; if (tmo4 !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", tmo4); end
        tick(1'b0);
        checks++; if (tmo4 !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b want 1", tmo4); end
        checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL tmo_valid: got %b want 0", valid4); end
        checks++; if (lck4 !== 1'b0) begin errors++; $display("FAIL tmo_locked: got %b want 0", lck4); end
        checks++; if (period4 !== 4'd4) begin errors++; $display("FAIL tmo_hold_period: got %0d want 4", period4); end
        tick(1'b0);
        checks++; if (tmo4 !== 1'b0) begin errors++; $display("FAIL tmo_one_cycle: got %b want 0", tmo4); end
        tick(1'b1);
        checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL tmo_ref_valid: got %b want 0", valid4); end
    endtask

    task automatic test_wrap();
        repeat (15) tick(1'b0);
        tick(1'b1);
        checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", valid4); end
        checks++; if (period4 !== 4'd0) begin errors++; $display("FAIL wrap_period: got %0d want 0", period4); end
        checks++; if (tmo4 !== 1'b0) begin errors++; $display("FAIL wrap_timeout: got %b want 0", tmo4); end
        tick(1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(1'b1);
        repeat (2) tick(1'b0);
        tick(1'b1);
        #2 rst = 1'b1;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_track_valid: got %b want 0", valid); end
        checks++; if (period !== 8'd0) begin errors++; $display("FAIL rstmid_track_period: got %0d want 0", period); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b1);
        for (int j = 0; j < 3; j++) begin
            repeat (2) tick(1'b0);
            tick(1'b1);
        end
        checks++; if (lck !== 1'b1) begin errors++; $display("FAIL rstmid_prelock: got %b want 1", lck); end
        tick(1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (lck !== 1'b0) begin errors++; $display("FAIL rstmid_lock_locked: got %b want 0", lck); end
        checks++; if (period !== 8'd0) begin errors++; $display("FAIL rstmid_lock_period: got %0d want 0", period); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b1);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_ref_valid: got %b want 0", valid); end
        repeat (2) tick(1'b0);
        tick(1'b1);
        checks++; if (period !== 8'd3) begin errors++; $display("FAIL rstmid_after_period: got %0d want 3", period); end
        checks++; if (lck !== 1'b0) begin errors++; $display("FAIL rstmid_after_locked: got %b want 0", lck); end
    endtask

    initial begin
        rst    = 1'b1;
        strobe = 1'b0;
        test_reset();
        test_div6();
        test_relock();
        test_held_high();
        test_duty50();
        test_timeout();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
